// File: rtl/usg_action_table.sv
// usg_action_table
//   Action stage of the USG firewall lookup path. A matched rule ID is turned
//   into a multi-bit action through a small table. Out-of-range IDs get a
//   default (miss) action. Every hit bumps a saturating per-entry counter.
//   The block also sits on the control-packet ring. It serves action
//   read/write and counter read/clear commands addressed to LMID, and passes
//   every other control packet through unchanged.
//
// Ports
//   clk, reset          clock, asynchronous active-low reset
//   ruleID_valid/ruleID lookup request (one per cycle)
//   action_valid/action/action_hit
//                       lookup result, 3 cycles after the request
//   cin_data_wr/cin_data/cin_ready
//                       control words in (buffered in a FIFO)
//   cout_data_wr/cout_data/cout_ready
//                       control words out (forwarded packets and replies)
module usg_action_table #(
  parameter int                  LMID           = 7,
  parameter int                  w_pkt          = 134,
  parameter int                  w_ruleID       = 16,
  parameter int                  w_action       = 4,
  parameter int                  d_actionTb     = 4,
  parameter int                  w_cnt          = 32,
  parameter int                  d_fifo         = 6,
  parameter logic [w_action-1:0] DEFAULT_ACTION = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ruleID_valid,
  input  logic [w_ruleID-1:0] ruleID,
  output logic                action_valid,
  output logic [w_action-1:0] action,
  output logic                action_hit,
  input  logic                cin_data_wr,
  input  logic [w_pkt-1:0]    cin_data,
  output logic                cin_ready,
  output logic                cout_data_wr,
  output logic [w_pkt-1:0]    cout_data,
  input  logic                cout_ready
);

  localparam int          N_ENT       = 1 << d_actionTb;
  localparam int          DEPTH       = 1 << d_fifo;
  localparam int unsigned READY_MAX_I = DEPTH - 4;
  localparam logic [d_fifo:0] READY_MAX = READY_MAX_I[d_fifo:0];
  localparam logic [7:0]  LMID_B      = LMID[7:0];

  localparam logic [2:0] OP_RD_ACT  = 3'b001;
  localparam logic [2:0] OP_WR_ACT  = 3'b010;
  localparam logic [2:0] OP_RD_CNT  = 3'b100;
  localparam logic [2:0] OP_CLR_CNT = 3'b101;

  typedef enum logic [2:0] {IDLE, HEAD, REPLY, FWD, DROP} state_t;

  function automatic logic [w_cnt-1:0] sat_inc(input logic [w_cnt-1:0] v);
    return (&v) ? v : v + {{(w_cnt-1){1'b0}}, 1'b1};
  endfunction

  // ---------------- control input FIFO ----------------
  logic [w_pkt-1:0]  fifo_mem [DEPTH];
  logic [d_fifo-1:0] wr_ptr, rd_ptr;
  logic [d_fifo:0]   fifo_cnt;
  logic              fifo_empty, fifo_full, push, pop;
  logic [w_pkt-1:0]  fifo_q;

  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = fifo_cnt[d_fifo];   // occupancy never exceeds DEPTH
  assign push       = cin_data_wr && !fifo_full;
  assign fifo_q     = fifo_mem[rd_ptr];
  // Headroom of 4 words absorbs words already in flight upstream.
  assign cin_ready  = (fifo_cnt <= READY_MAX);

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= cin_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + {{(d_fifo-1){1'b0}}, 1'b1};
      if (pop)  rd_ptr <= rd_ptr + {{(d_fifo-1){1'b0}}, 1'b1};
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + {{d_fifo{1'b0}}, 1'b1};
        2'b01:   fifo_cnt <= fifo_cnt - {{d_fifo{1'b0}}, 1'b1};
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // ---------------- control FSM ----------------
  state_t                  state, nxt;
  logic [w_pkt-1:0]        hdr;
  logic [63:0]             reply_data;
  logic                    hdr_ld, tbl_we, clr_en, cap_en;
  logic [2:0]              hdr_op;
  logic [d_actionTb-1:0]   hdr_idx;
  logic                    for_me, hdr_last;
  state_t                  end_nxt;
  logic [w_pkt-1:0]        reply_word;

  logic [w_action-1:0] tbl [N_ENT];
  logic [w_cnt-1:0]    cnt [N_ENT];

  assign hdr_op   = hdr[126:124];
  assign hdr_idx  = hdr[72 +: d_actionTb];
  assign for_me   = (hdr[103:96] == LMID_B);
  // Tags 00 (single word) and 10 (tail) both have bit 132 clear.
  assign hdr_last = ~hdr[132];
  assign end_nxt  = hdr_last ? IDLE : DROP;
  assign reply_word = {2'b00, hdr[131:127], 3'b011, hdr[123:112],
                       hdr[103:96], hdr[111:104], hdr[95:64], reply_data};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= nxt;
  end

  always_comb begin
    nxt          = state;
    pop          = 1'b0;
    hdr_ld       = 1'b0;
    tbl_we       = 1'b0;
    clr_en       = 1'b0;
    cap_en       = 1'b0;
    cout_data_wr = 1'b0;
    cout_data    = '0;
    case (state)
      IDLE: begin
        if (!fifo_empty && cout_ready) begin
          pop    = 1'b1;
          hdr_ld = 1'b1;
          nxt    = HEAD;
        end
      end
      HEAD: begin
        if (!for_me) begin
          if (cout_ready) begin
            cout_data_wr = 1'b1;
            cout_data    = hdr;
            nxt          = hdr_last ? IDLE : FWD;
          end
        end else begin
          case (hdr_op)
            OP_RD_ACT, OP_RD_CNT: begin
              cap_en = 1'b1;
              nxt    = REPLY;
            end
            OP_WR_ACT: begin
              tbl_we = 1'b1;
              nxt    = end_nxt;
            end
            OP_CLR_CNT: begin
              clr_en = 1'b1;
              nxt    = end_nxt;
            end
            default: nxt = end_nxt;
          endcase
        end
      end
      REPLY: begin
        if (cout_ready) begin
          cout_data_wr = 1'b1;
          cout_data    = reply_word;
          nxt          = end_nxt;
        end
      end
      FWD: begin
        if (!fifo_empty && cout_ready) begin
          cout_data_wr = 1'b1;
          cout_data    = fifo_q;
          pop          = 1'b1;
          if (fifo_q[133:132] == 2'b10) nxt = IDLE;
        end
      end
      DROP: begin
        if (!fifo_empty && cout_ready) begin
          pop = 1'b1;
          if (fifo_q[133:132] == 2'b10) nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (hdr_ld) hdr <= fifo_q;
    if (cap_en) reply_data <= (hdr_op == OP_RD_ACT) ? 64'(tbl[hdr_idx])
                                                    : 64'(cnt[hdr_idx]);
  end

  // ---------------- lookup pipeline ----------------
  logic                  vld_p0, vld_p1, vld_p2;
  logic                  hit_p0, hit_p1, hit_p2;
  logic [d_actionTb-1:0] idx_p0;
  logic [w_action-1:0]   act_p0, act_p1, act_p2;
  logic                  inc_en;

  assign inc_en = vld_p0 && hit_p0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p0       <= 1'b0;
      vld_p1       <= 1'b0;
      vld_p2       <= 1'b0;
      action_valid <= 1'b0;
      action       <= '0;
      action_hit   <= 1'b0;
    end else begin
      vld_p0       <= ruleID_valid;
      vld_p1       <= vld_p0;
      vld_p2       <= vld_p1;
      action_valid <= vld_p2;
      if (vld_p2) begin
        action     <= act_p2;
        action_hit <= hit_p2;
      end
    end
  end

  always_ff @(posedge clk) begin
    // p0: table read at request time, so a write landing on this same edge
    // is not seen by this lookup
    hit_p0 <= (ruleID[w_ruleID-1:d_actionTb] == '0);
    idx_p0 <= ruleID[d_actionTb-1:0];
    act_p0 <= tbl[ruleID[d_actionTb-1:0]];
    // p1: resolve miss to default action
    hit_p1 <= hit_p0;
    act_p1 <= hit_p0 ? act_p0 : DEFAULT_ACTION;
    // p2
    hit_p2 <= hit_p1;
    act_p2 <= act_p1;
  end

  // ---------------- table and hit counters ----------------
  // Counters update in place every cycle, so back-to-back hits on one entry
  // each count. A clear on the same edge as an increment wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N_ENT; i++) begin
        tbl[i] <= '0;
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < N_ENT; i++) begin
        if (tbl_we && hdr_idx == i[d_actionTb-1:0]) tbl[i] <= hdr[w_action-1:0];
        if (clr_en && hdr_idx == i[d_actionTb-1:0])      cnt[i] <= '0;
        else if (inc_en && idx_p0 == i[d_actionTb-1:0])  cnt[i] <= sat_inc(cnt[i]);
      end
    end
  end

endmodule

// File: doc/usg_action_table.md
# usg_action_table

Parametrised next-generation action stage for the USG firewall. Turns a matched rule ID into a multi-bit action, adds a miss/default action and per-rule saturating hit counters. Sits after the rule classifier on the lookup path and on the control-packet ring (cin/cout), where it serves action read/write and counter read/clear commands addressed to its LMID and forwards all other control packets unchanged.

## Interface
- LMID, 7, local module ID matched against command word bits [103:96]
- w_pkt, 134, control word width
- w_ruleID, 16, rule ID width
- w_action, 4, action width
- d_actionTb, 4, log2 of table entries (16 entries)
- w_cnt, 32, hit counter width (≤64)
- d_fifo, 6, log2 of control input FIFO depth (64 words)
- DEFAULT_ACTION, 4'd0, action returned on miss
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ruleID_valid  in  1  lookup request strobe
- ruleID  in  w_ruleID  rule ID to look up
- action_valid  out  1  lookup result strobe
- action  out  w_action  resulting action
- action_hit  out  1  1 = table hit, 0 = miss/default
- cin_data_wr  in  1  control word write
- cin_data  in  w_pkt  control word
- cin_ready  out  1  control input may accept words
- cout_data_wr  out  1  control word output strobe
- cout_data  out  w_pkt  control word out
- cout_ready  in  1  downstream may accept words

## Operation
- Word fields: [133:132] tag (01 head, 11 body, 10 tail, 00 head+tail single word), [126:124] opcode, [111:104] src, [103:96] dst, [71+d_actionTb:72] index, [63:0] data.
- Table: 2^d_actionTb entries of {w_action action}; per-entry w_cnt counter. All entries and counters reset to 0.
- Lookup: hit iff ruleID[w_ruleID-1:d_actionTb]==0; index = ruleID[d_actionTb-1:0]. Hit → action = entry, action_hit=1, counter += 1 saturating at all-ones. Miss → action = DEFAULT_ACTION, action_hit=0, no counter change. One lookup per cycle sustained; back-to-back hits on the same index must each count.
- Control FSM states: IDLE, HEAD, REPLY, FWD, DROP.
  - IDLE: FIFO non-empty and cout_ready=1 → pop head, go HEAD.
  - HEAD: dst≠LMID → emit word, go FWD (or IDLE if tag 00/10). dst=LMID: opcode 001 read action / 100 read counter → capture, go REPLY; 010 write action (table ← data[w_action-1:0]) / 101 clear counter → apply, go DROP (or IDLE if tag 00/10); other opcodes → DROP/IDLE, no effect.
  - REPLY: emit one word {2'b00, in[131:127], 3'b011, in[123:112], in[103:96], in[111:104], in[95:64], data}, data = zero-extended action or counter; then DROP/IDLE per head tag.
  - FWD: forward each word while cout_ready=1, until tag 10 → IDLE.
  - DROP: pop and discard until tag 10 → IDLE.
- Same-cycle conflicts: config write vs lookup on same index → lookup returns old value; clear vs increment on same counter → clear wins (counter = 0).
- cin_ready = FIFO occupancy ≤ 2^d_fifo − 4. Words written when FIFO full are dropped.

## Timing
- Lookup latency fixed 3 cycles: ruleID_valid at edge N → action_valid at N+3, one cycle per request.
- Counter visible to counter-read commands no later than 3 cycles after the lookup.
- Config write takes effect for lookups issued ≥1 cycle after the HEAD cycle.
- cout_data_wr is asserted only while cout_ready=1; cout_ready low stalls FWD/DROP/REPLY with no word lost or duplicated.
- Reset values: action_valid 0, action 0, action_hit 0, cout_data_wr 0, cout_data 0, cin_ready 1, FSM IDLE, FIFO empty. Reset mid-packet aborts the packet; the next word after reset is treated as a head.

## Test plan
- Write entry 5 = 4'hA (op 010, dst=LMID), then lookup ruleID 5 → action_valid 3 cycles later, action 4'hA, action_hit 1.
- Lookup ruleID 16'h0015 → action DEFAULT_ACTION, action_hit 0; counter of entry 5 unchanged.
- 10 back-to-back lookups of ruleID 3, then counter read (op 100) → reply opcode 011, src/dst swapped, data 10; clear (op 101) then read → 0.
- 3-word packet with dst≠LMID, cout_ready toggled every cycle → identical 3 words out, in order, none duplicated.
- Counter preset to all-ones − 1 (w_cnt=4), 3 hits → counter saturates at 4'hF; clear coinciding with a hit → 0.
- Assert reset during FWD of a 4-word packet → outputs at reset values; next clean single-word read returns correct reply.
